// File: rtl/fifo_serializer_pkg.sv
// Shared types and sizing helpers for the FIFO-to-serial converter.
// FIFO_SERIALIZER_PARITY_EN appends an odd-parity bit after each word.
package fifo_serializer_pkg;

  typedef enum logic [1:0] {IDLE, POP, LOAD, SHIFT} state_t;

  function automatic int nbits(input int width);
`ifdef FIFO_SERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO read port plus serial link handshake and status, seen from the serializer (master).
interface fifo_serializer_if #(parameter int WIDTH = 16);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_read;
  logic             ser_ready;
  logic             ser_valid;
  logic             ser_out;
  logic             ser_start;
  logic             busy;
  logic [15:0]      words_sent;

  modport master (
    input  fifo_empty, fifo_data_out, ser_ready,
    output fifo_read, ser_valid, ser_out, ser_start, busy, words_sent
  );

  modport slave (
    output fifo_empty, fifo_data_out, ser_ready,
    input  fifo_read, ser_valid, ser_out, ser_start, busy, words_sent
  );
endinterface

// File: rtl/fifo_serializer_piso_shift.sv
// Parallel-load, shift-left register; zero fills the LSB and load wins over shift.
module piso_shift #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         msb
);
  logic [W-1:0] r_sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_sreg <= '0;
    else if (load)  r_sreg <= d;
    else if (shift) r_sreg <= {r_sreg[W-2:0], 1'b0};
  end

  assign msb = r_sreg[W-1];
endmodule

// File: rtl/fifo_serializer.sv
// Pops words from a FIFO and shifts them out MSB-first over a valid/ready serial link.
// Optional trailing odd-parity bit under FIFO_SERIALIZER_PARITY_EN.
module fifo_serializer
  import fifo_serializer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  fifo_serializer_if.master  bus
);
  localparam int            NBITS = nbits(WIDTH);
  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(NBITS - 1);

  state_t           r_state, w_next;
  logic [CW-1:0]    r_bit_cnt;
  logic [15:0]      r_words_sent;
  logic [NBITS-1:0] w_load_word;
  logic             w_load, w_shift, w_msb, w_done;

`ifdef FIFO_SERIALIZER_PARITY_EN
  assign w_load_word = {bus.fifo_data_out, ~^bus.fifo_data_out};
`else
  assign w_load_word = bus.fifo_data_out;
`endif

  assign w_load  = (r_state == LOAD);
  assign w_shift = (r_state == SHIFT) && bus.ser_ready;
  assign w_done  = w_shift && (r_bit_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!bus.fifo_empty) w_next = POP;
      POP:     w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt    <= '0;
      r_words_sent <= '0;
    end else begin
      if (w_load)       r_bit_cnt <= LAST;
      else if (w_shift) r_bit_cnt <= r_bit_cnt - 1'b1;
      if (w_done)       r_words_sent <= r_words_sent + 16'd1;
    end
  end

  piso_shift #(.W(NBITS)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .d     (w_load_word),
    .msb   (w_msb)
  );

  // Pop is combinational off the empty flag; gating with rst keeps it low during reset.
  assign bus.fifo_read  = rst && (r_state == IDLE) && !bus.fifo_empty;
  assign bus.ser_valid  = (r_state == SHIFT);
  assign bus.ser_out    = (r_state == SHIFT) && w_msb;
  assign bus.ser_start  = (r_state == SHIFT) && (r_bit_cnt == LAST);
  assign bus.busy       = (r_state != IDLE);
  assign bus.words_sent = r_words_sent;
endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench: FIFO model feeds the DUT, an expected-bit queue checks the serial stream.
module tb_fifo_serializer;
  localparam int W = 16;
`ifdef FIFO_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_serializer_if #(.WIDTH(W)) bus ();
  fifo_serializer #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int          n_tests = 0, n_fail = 0;
  int          cyc_n = 0, bit_idx = 0, ready_mode = 0, pat_i = 0;
  logic [W-1:0] q_fifo[$];
  logic        q_bits[$];
  int          read_cycles[$], start_cycles[$];
  logic [15:0] exp_ws = 16'd0;
  logic        prev_stall = 1'b0, prev_out = 1'b0, prev_start = 1'b0, last_bit = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    q_fifo.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic model_reset();
    q_bits.delete();
    bit_idx = 0; exp_ws = 16'd0;
    prev_stall = 1'b0; prev_start = 1'b0;
  endtask

  // One clock: observe at negedge, then update FIFO model and inputs just after posedge.
  task automatic cyc();
    logic         do_pop;
    logic [W-1:0] w;
    @(negedge clk);
    cyc_n++;
    chk("words_sent", bus.words_sent, exp_ws);
    chk("read_while_empty", bus.fifo_read & bus.fifo_empty, 0);
    if (prev_stall) chk("stall_hold", bus.ser_out, prev_out);
    if (bus.ser_valid === 1'b1) begin
      chk("ser_start", bus.ser_start, bit_idx == 0);
      if (bus.ser_ready) begin
        if (q_bits.size() == 0) chk("extra_bit", 1, 0);
        else chk("ser_bit", bus.ser_out, q_bits.pop_front());
        last_bit = bus.ser_out;
        bit_idx  = (bit_idx + 1) % NB;
        if (bit_idx == 0) exp_ws = exp_ws + 16'd1;
      end
    end else begin
      chk("start_when_invalid", bus.ser_start, 0);
    end
    if (bus.ser_start === 1'b1 && !prev_start) start_cycles.push_back(cyc_n);
    prev_start = (bus.ser_start === 1'b1);
    prev_stall = (bus.ser_valid === 1'b1) && !bus.ser_ready;
    prev_out   = bus.ser_out;
    do_pop     = (bus.fifo_read === 1'b1) && (q_fifo.size() != 0);
    @(posedge clk); #1;
    if (do_pop) begin
      w = q_fifo.pop_front();
      bus.fifo_data_out = w;
      for (int i = W - 1; i >= 0; i--) q_bits.push_back(w[i]);
`ifdef FIFO_SERIALIZER_PARITY_EN
      q_bits.push_back(~^w);
`endif
      read_cycles.push_back(cyc_n);
    end
    bus.fifo_empty = (q_fifo.size() == 0);
    case (ready_mode)
      0:       bus.ser_ready = 1'b1;
      1:       begin bus.ser_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
      default: bus.ser_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_idle(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      cyc();
      if (q_fifo.size() == 0 && q_bits.size() == 0 && bus.busy === 1'b0) break;
    end
    chk({tag, "_done"}, k < budget, 1);
  endtask

  initial begin
    logic [15:0] ws0;
    int k;
    bus.fifo_empty = 1'b1; bus.fifo_data_out = '0; bus.ser_ready = 1'b0;

    // Reset held two cycles
    cyc(); cyc();
    chk("rst_outputs", {bus.fifo_read, bus.ser_valid, bus.ser_out, bus.ser_start, bus.busy}, 0);
    chk("rst_ws", bus.words_sent, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("idle_busy", bus.busy, 0);

    // Single word with latency check
    read_cycles.delete(); start_cycles.delete();
    push_word(16'h0005);
    run_idle("single", 100);
    chk("single_reads", read_cycles.size(), 1);
    chk("single_starts", start_cycles.size(), 1);
    if (read_cycles.size() == 1 && start_cycles.size() == 1)
      chk("single_latency", start_cycles[0] - read_cycles[0], 3);
    chk("single_ws", bus.words_sent, 1);
    chk("single_busy", bus.busy, 0);

    // Back-pressure with 1,0,0,1 ready pattern
    ready_mode = 1; pat_i = 0;
    push_word(16'hA5A5);
    run_idle("bp", 300);
    chk("bp_ws", bus.words_sent, 2);

    // Drain five words back-to-back
    ready_mode = 0; bus.ser_ready = 1'b1;
    read_cycles.delete(); ws0 = bus.words_sent;
    for (int i = 5; i >= 1; i--) push_word(W'(i));
    run_idle("drain", 400);
    chk("drain_reads", read_cycles.size(), 5);
    for (int i = 1; i < read_cycles.size(); i++)
      chk("drain_spacing", read_cycles[i] - read_cycles[i-1], NB + 3);
    chk("drain_ws", bus.words_sent - ws0, 5);

`ifdef FIFO_SERIALIZER_PARITY_EN
    push_word(16'h0005);
    run_idle("par5", 100);
    chk("par5_bit", last_bit, 1);
    push_word(16'h0007);
    run_idle("par7", 100);
    chk("par7_bit", last_bit, 0);
`endif

    // Reset after 8 bits of 16'hFFFF
    push_word(16'hFFFF);
    for (k = 0; k < 100; k++) begin
      cyc();
      if (bit_idx == 8) break;
    end
    chk("mid_reach8", k < 100, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_outputs", {bus.fifo_read, bus.ser_valid, bus.ser_out, bus.ser_start, bus.busy}, 0);
    chk("mid_rst_ws", bus.words_sent, 0);
    model_reset();
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    push_word(16'h1234);
    run_idle("after_rst", 100);
    chk("after_rst_ws", bus.words_sent, 1);

    // Random words with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 20; i++) push_word(W'($urandom));
    run_idle("rand", 3000);
    chk("rand_ws", bus.words_sent, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_serializer.md
# fifo_serializer

Downstream consumer of the `fifo` block. It pops one WIDTH-bit word whenever the FIFO is non-empty and shifts the word out MSB-first on a 1-bit serial line with a valid/ready handshake. An optional parity bit can follow each word. The block sits between the FIFO read port and the serial link transmitter.

## Interface
- WIDTH, 16, word width; must match the FIFO WIDTH (≥2)
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data_out  in  WIDTH  FIFO read data; valid in the cycle after a `fifo_read` pulse
- fifo_read  out  1  one-cycle pop request to the FIFO
- ser_ready  in  1  sink accepts the current bit when high together with `ser_valid`
- ser_valid  out  1  current serial bit is valid
- ser_out  out  1  serial data bit
- ser_start  out  1  high while the first bit of a word (the MSB) is presented
- busy  out  1  high in every state except IDLE
- words_sent  out  16  count of fully transmitted words; wraps 16'hFFFF→0

## Operation
- FSM states are IDLE, POP, LOAD and SHIFT.
- **IDLE**
  - `fifo_read` = !fifo_empty, driven combinationally.
  - If !fifo_empty → POP. Otherwise stay in IDLE.
- **POP**
  - Waits one cycle for the registered FIFO read data; `fifo_read`=0.
  - Always → LOAD.
- **LOAD**
  - Captures `fifo_data_out` into the shift register sreg.
  - Loads bit_cnt = NBITS-1. NBITS = WIDTH, or WIDTH+1 when parity is enabled.
  - Always → SHIFT.
- **SHIFT**
  - `ser_valid`=1, `ser_out`=sreg[MSB], `ser_start` = (bit_cnt==NBITS-1).
  - When `ser_ready`=1: shift sreg left by one (0 fills the LSB) and decrement bit_cnt.
  - When `ser_ready`=1 and bit_cnt==0: increment words_sent and go → IDLE.
  - When `ser_ready`=0: hold all state; `ser_out` stays stable.
- `fifo_read` is never asserted while `fifo_empty`=1 and never in POP, LOAD or SHIFT. At most one pop is outstanding.
- bit_cnt width is $clog2(WIDTH+1). words_sent is an unsigned modulo-2^16 counter.

## Timing
- Reset values (asynchronous, rst=0): state=IDLE, sreg=0, bit_cnt=0, words_sent=0.
  - Outputs under reset: `fifo_read`=0, `ser_valid`=0, `ser_out`=0, `ser_start`=0, `busy`=0.
- Latency: with the FIFO non-empty in cycle N, `fifo_read` is high in N.
  - The first bit is valid in N+3.
  - The FIFO itself registers data in N+1.
- Throughput with `ser_ready` tied high: one word per NBITS+3 cycles.
  - The cycle after the last bit is accepted is IDLE, and a new pop may start there.
- If `fifo_empty` rises during SHIFT, there is no effect; the current word completes.
- If reset is asserted mid-word, the word is abandoned.
  - A pop issued before reset is lost; this block does not recover it.
- If `ser_ready` drops, the transfer stalls indefinitely with no timeout. `busy` stays 1.

## Configuration
- Macro: `FIFO_SERIALIZER_PARITY_EN`.
- **Defined:** after the LSB, one extra bit = ~^word (odd parity, so the total count of 1s over data plus parity is odd). NBITS = WIDTH+1.
  - In LOAD, sreg is WIDTH+1 bits holding {word, parity}.
- **Undefined:** no parity bit; NBITS = WIDTH and sreg is WIDTH bits.

## Structure
- Package `fifo_serializer_pkg` contains:
  - the `state_t` enum (IDLE, POP, LOAD, SHIFT), 2-bit logic;
  - localparam helper function nbits(width) that returns the parity-adjusted width.
- Sub-module `piso_shift`: a parallel-load, shift-enable register with `load`, `shift`, `d` and `msb` ports. The FSM, counter and handshake logic stay in the top module.

## Test plan
- **Reset:** hold rst=0 for 2 cycles, then release.
  - All outputs are 0 and words_sent=0.
  - `fifo_read` stays 0 while `fifo_empty`=1.
- **Single word:** FIFO holds 16'h0005, ser_ready=1.
  - `fifo_read` pulses once; 3 cycles later `ser_start`=1.
  - Bit stream is 0000000000000101, words_sent=1, then IDLE with `busy`=0.
- **Back-pressure:** word 16'hA5A5 with ser_ready toggled 1,0,0,1,...
  - Each bit is held while ser_ready=0.
  - The full stream is 1010010110100101 with no bit lost or duplicated.
- **Drain five words:** words 5,4,3,2,1 written, ser_ready=1.
  - Exactly 5 `fifo_read` pulses, each spaced NBITS+3 cycles apart.
  - words_sent=5; `fifo_read` is never high while `fifo_empty`=1.
- **Parity (macro defined):** word 16'h0005 → 17 bits ending in parity=1. Word 16'h0007 → parity=0.
- **Reset mid-word:** after 8 bits of 16'hFFFF, assert rst.
  - All outputs go to 0 immediately and words_sent=0.
  - After release, the next word transmits normally.
